uart_transmitter: RTL and testbench



---
 rtl/uart_transmitter.sv | 158 +++++++++++++++
 tb/tb_uart_transmitter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmit serialiser: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Parity uses the receiver's convention: parity = ^data ^ pType (pType=1 means odd).
//
// Handshake: send is a request strobe with no ready/valid pairing beyond busy.
// A send is accepted at a rising edge where send=1, busy=0 and rst=0. Once
// accepted, busy stays high for the whole frame. A send seen while busy is
// dropped, and it does not disturb the latched word. done pulses for exactly one
// cycle, on the last cycle of the final stop bit. busy falls on the following
// cycle.
module uart_transmitter #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  send,
  input  logic                  parityEn,
  input  logic                  pType,
  output logic                  tx,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Wide enough for both the data-bit index and the stop-bit index.
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_nx;
  logic [DIV_W-1:0]      div, div_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic                  par_en, par_en_nx;
  logic                  par_bit, par_bit_nx;
  logic                  tx_nx, busy_nx, done_nx;
  logic                  tick;

  // Bit-period boundary: the divider is about to wrap.
  assign tick      = (div == DIV_LAST);
  assign state_dbg = state;

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      cnt     <= '0;
      shreg   <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      div     <= div_nx;
      cnt     <= cnt_nx;
      shreg   <= shreg_nx;
      par_en  <= par_en_nx;
      par_bit <= par_bit_nx;
      tx      <= tx_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  // Next-state logic. Outputs are decoded from the next state so that they
  // register in step with the state they belong to.
  always_comb begin
    state_nx   = state;
    div_nx     = div;
    cnt_nx     = cnt;
    shreg_nx   = shreg;
    par_en_nx  = par_en;
    par_bit_nx = par_bit;

    if (state != IDLE) begin
      div_nx = tick ? '0 : div + 1'b1;
    end

    case (state)
      IDLE: begin
        if (send) begin
          state_nx   = START;
          div_nx     = '0;
          cnt_nx     = '0;
          shreg_nx   = dataIn;
          par_en_nx  = parityEn;
          par_bit_nx = (^dataIn) ^ pType;
        end
      end
      START: begin
        if (tick) begin
          state_nx = DATA;
          cnt_nx   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_nx = shreg >> 1;
          if (cnt == DATA_LAST) begin
            cnt_nx   = '0;
            state_nx = par_en ? PARITY : STOP;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_nx = STOP;
          cnt_nx   = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (cnt == STOP_LAST) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        div_nx   = '0;
        cnt_nx   = '0;
      end
    endcase

    tx_nx = 1'b1;
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shreg_nx[0];
      PARITY:  tx_nx = par_bit_nx;
      default: tx_nx = 1'b1;
    endcase

    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == STOP) && (div_nx == DIV_LAST) && (cnt_nx == STOP_LAST);
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1.
// A line monitor decodes tx against words queued at send time.
module tb_uart_transmitter;

  localparam int CPB = 4;

  // Clock and reset
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dataIn;
  logic       send;
  logic       parityEn;
  logic       pType;
  logic       tx;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;
  bit         rst_seen = 1'b1;

  always #5 clk = ~clk;

  // Registered copy of rst, so the monitor sees what the DUT saw at the last edge.
  always @(posedge clk) rst_seen <= rst;

  uart_transmitter #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dataIn   (dataIn),
    .send     (send),
    .parityEn (parityEn),
    .pType    (pType),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .state_dbg(state_dbg)
  );

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];  // {parityEn, pType, data}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int frame_len(input logic pe);
    return CPB * (1 + 8 + (pe ? 1 : 0) + 1);
  endfunction

  // Driver tasks (called at a falling edge; accept happens at the next rising edge)
  task automatic send_word(input logic [7:0] d, input logic pe, input logic pt);
    dataIn   = d;
    parityEn = pe;
    pType    = pt;
    send     = 1'b1;
    exp_q.push_back({pe, pt, d});
    @(negedge clk);
    send = 1'b0;
  endtask

  // Line monitor / model receiver
  logic        rx_busy = 1'b0;
  int          rx_c;
  int          rx_len;
  logic [9:0]  rx_exp;
  logic [11:0] rx_bits;
  logic [2:0]  rx_states[12];
  logic [11:0] rx_samp;
  logic [9:0]  rx_drop;
  logic [7:0]  rx_data;
  logic        rx_err;

  always @(negedge clk) begin
    if (rst_seen) begin
      if (rx_busy && exp_q.size() > 0) rx_drop = exp_q.pop_front();
      rx_busy = 1'b0;
    end else begin
      if (!rx_busy) begin
        if (tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            check("rx_unexpected_start", 0, 1);
          end else begin
            rx_exp  = exp_q[0];
            rx_bits = '1;
            rx_bits[0]   = 1'b0;
            rx_bits[8:1] = rx_exp[7:0];
            for (int i = 0; i < 12; i++) rx_states[i] = 3'd4;
            rx_states[0] = 3'd1;
            for (int i = 1; i <= 8; i++) rx_states[i] = 3'd2;
            if (rx_exp[9]) begin
              rx_bits[9]   = (^rx_exp[7:0]) ^ rx_exp[8];
              rx_states[9] = 3'd3;
            end
            rx_len  = frame_len(rx_exp[9]);
            rx_c    = 0;
            rx_samp = '1;
            rx_busy = 1'b1;
          end
        end else begin
          check("idle_done", done, 0);
        end
      end
      if (rx_busy) begin
        if (rx_c < rx_len) begin
          check("tx_bit", tx, rx_bits[rx_c / CPB]);
          check("frame_busy", busy, 1);
          check("frame_done", done, (rx_c == rx_len - 1) ? 1 : 0);
          check("frame_state", state_dbg, rx_states[rx_c / CPB]);
          if (rx_c % CPB == CPB / 2) rx_samp[rx_c / CPB] = tx;
          rx_c++;
        end else begin
          check("end_busy", busy, 0);
          check("end_done", done, 0);
          check("end_tx", tx, 1);
          rx_data = rx_samp[8:1];
          check("rx_data", rx_data, rx_exp[7:0]);
          if (rx_exp[9]) begin
            rx_err = ((^rx_data) ^ rx_samp[9]) != rx_exp[8];
            check("rx_parity_err", rx_err, 0);
          end
          rx_drop = exp_q.pop_front();
          rx_busy = 1'b0;
        end
      end
    end
  end

  // Stimulus
  logic [7:0] lb_words[3];
  logic [7:0] rd;
  logic       rpe;
  logic       rpt;

  initial begin
    rst      = 1'b1;
    send     = 1'b1;
    dataIn   = 8'h5A;
    parityEn = 1'b1;
    pType    = 1'b1;

    // Reset held with send asserted: nothing may start.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_state", state_dbg, 0);
    end
    rst  = 1'b0;
    send = 1'b0;
    @(negedge clk);
    check("post_rst_tx", tx, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    repeat (3) @(negedge clk);

    // Odd parity, cycle-exact.
    send_word(8'b0100_1111, 1'b1, 1'b1);
    repeat (frame_len(1'b1)) @(negedge clk);
    repeat (2) @(negedge clk);

    // Even parity, then no parity.
    send_word(8'hA5, 1'b1, 1'b0);
    repeat (frame_len(1'b1)) @(negedge clk);
    send_word(8'hA5, 1'b0, 1'b0);
    repeat (frame_len(1'b0)) @(negedge clk);
    repeat (2) @(negedge clk);

    // Send while busy is ignored, and input changes do not reach the frame.
    send_word(8'h96, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    dataIn   = 8'hFF;
    parityEn = 1'b0;
    pType    = 1'b1;
    send     = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (frame_len(1'b1) - 10) @(negedge clk);
    repeat (6) @(negedge clk);

    // Reset in the middle of a frame.
    send_word(8'h3C, 1'b1, 1'b1);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_state", state_dbg, 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    send_word(8'hC3, 1'b0, 1'b0);
    repeat (frame_len(1'b0)) @(negedge clk);

    // Loopback set, back-to-back with the minimum one-cycle gap.
    lb_words[0] = 8'h00;
    lb_words[1] = 8'hFF;
    lb_words[2] = 8'h5A;
    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w < 3; w++) begin
        send_word(lb_words[w], 1'b1, p[0]);
        repeat (frame_len(1'b1)) @(negedge clk);
      end
    end

    // A few random frames.
    for (int k = 0; k < 6; k++) begin
      rd  = 8'($urandom_range(0, 255));
      rpe = 1'($urandom_range(0, 1));
      rpt = 1'($urandom_range(0, 1));
      send_word(rd, rpe, rpt);
      repeat (frame_len(rpe)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
